mod_reduce: RTL
===============

MOD_REDUCE -- requirements
Module: mod_reduce

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, which is the modulus/remainder width; the input value width is 2*BITWIDTH; legal range is BITWIDTH >= 2.
REQ-002 SHALL have port sys_clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream (squarer result) valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a new operand.
REQ-006 SHALL have port in_value, input, 2*BITWIDTH bits: dividend, i.e. the square product.
REQ-007 SHALL have port in_mod, input, BITWIDTH bits: modulus q.
REQ-008 SHALL have port in_double, input, 1 bit: 1 = reduce 2*in_value instead of in_value (exponent bit set).
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_rem, output, BITWIDTH bits: remainder.
REQ-012 SHALL have port out_err, output, 1 bit: the modulus was zero.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL assert in_ready only in IDLE, and SHALL assert out_valid only in DONE.
REQ-015 On the edge with in_valid&&in_ready, SHALL latch in_mod and the dividend D as a (2*BITWIDTH+1)-bit value: {in_value,1'b0} if in_double, else {1'b0,in_value}.
REQ-016 On that same edge, SHALL clear the (BITWIDTH+1)-bit partial remainder r, load the bit counter with 2*BITWIDTH+1, and go to SHIFT; if the latched modulus is 0, SHALL go to DONE instead.
REQ-017 Each SHIFT edge, SHALL compute t = (r<<1) | next MSB of D, then set r = (t >= q) ? t-q : t, and decrement the counter; all compares and subtracts are BITWIDTH+1 bits wide.
REQ-018 SHALL spend exactly 2*BITWIDTH+1 edges in SHIFT, independent of in_double and data values; on the last SHIFT edge, SHALL go to DONE.
REQ-019 On entry to DONE, SHALL load out_rem with r[BITWIDTH-1:0] and set out_err=0; on a zero-modulus entry, SHALL set out_rem=0 and out_err=1.
REQ-020 Latency: out_valid SHALL first be high 2*BITWIDTH+2 edges after the accept edge, or 1 edge after it for q=0.
REQ-021 In DONE, out_valid, out_rem and out_err SHALL stay stable until an edge with out_ready=1; on that edge, SHALL return to IDLE.
REQ-022 SHALL NOT bypass: in_ready SHALL be 0 during the DONE->IDLE handoff cycle, so the next accept occurs at the earliest one edge after the output handshake.
REQ-023 in_value, in_mod and in_double changes outside the accept edge SHALL have no effect on an operation in progress.
REQ-024 Result invariant: out_rem = (in_double ? 2*in_value : in_value) mod in_mod, always < in_mod; in_mod=1 SHALL give 0.
REQ-025 out_rem and out_err SHALL hold their last values in IDLE and SHIFT.

Reset
REQ-026 When sys_rst_n=0, SHALL immediately force: state IDLE, out_valid=0, in_ready=1 once reset is released, out_rem=0, out_err=0, r=0, counter=0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation, with no output handshake afterwards.
REQ-028 The first accept SHALL be possible on the first rising edge after reset deassertion.

Verification
REQ-029 BITWIDTH=32, in_value=100, in_mod=7, in_double=0 -> out_rem=2, out_err=0, out_valid first high exactly 66 edges after accept.
REQ-030 in_value=1024, in_mod=23, in_double=1 -> out_rem=1 (2^11 mod 23); in_value=100, in_mod=7, in_double=1 -> out_rem=4.
REQ-031 in_value=64'hFFFFFFFF_FFFFFFFF, in_mod=32'hFFFFFFFF, both in_double values -> out_rem=0; in_mod=32'hFFFFFFFF with in_value=5 -> out_rem=5.
REQ-032 in_mod=0, any in_value -> out_err=1, out_rem=0, out_valid one edge after accept; next valid operand -> out_err=0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while changing the inputs -> outputs stable, in_ready=0; raise out_ready -> IDLE, then next accept with correct result.
REQ-034 Assert sys_rst_n=0 at SHIFT cycle 20 -> outputs zero asynchronously, no out_valid; back-to-back random operands afterwards match the reference a mod q.

Source files
------------

// File: rtl/mod_reduce.sv
// mod_reduce: bit-serial restoring reduction of a 2*BITWIDTH-bit square (optionally doubled) modulo q.
// Latency: 2*BITWIDTH+1 SHIFT cycles after accept (DONE entered on accept edge for q=0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle rearm.
module mod_reduce #(
  parameter int BITWIDTH = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*BITWIDTH-1:0]   in_value,
  input  logic [BITWIDTH-1:0]     in_mod,
  input  logic                    in_double,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITWIDTH-1:0]     out_rem,
  output logic                    out_err
);

  // Dividend carries one extra bit so the doubled product fits without overflow.
  localparam int DW = 2 * BITWIDTH + 1;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [DW-1:0]       d_q;
  logic [BITWIDTH-1:0] q_q;
  logic [BITWIDTH:0]   r_q;
  logic [CW-1:0]       cnt_q;
  logic [BITWIDTH-1:0] rem_q;
  logic                err_q;

  logic [BITWIDTH:0]   t_d;
  logic [BITWIDTH:0]   r_d;

  // One restoring-division step: shift in the next dividend MSB, subtract q when it fits.
  always_comb begin
    t_d = (r_q << 1) | {{BITWIDTH{1'b0}}, d_q[DW-1]};
    r_d = t_d;
    if (t_d >= {1'b0, q_q}) begin
      r_d = t_d - {1'b0, q_q};
    end
  end

  // Handshake flags decode straight from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_rem   = rem_q;
    out_err   = err_q;
  end

  // Control FSM plus datapath registers; results only change when DONE is entered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q   <= in_double ? {in_value, 1'b0} : {1'b0, in_value};
            q_q   <= in_mod;
            r_q   <= '0;
            cnt_q <= CW'(DW);
            if (in_mod == '0) begin
              state_q <= DONE;
              rem_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_q   <= r_d;
          d_q   <= {d_q[DW-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            rem_q   <= r_d[BITWIDTH-1:0];
            err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
